// File: rtl/pkt_enq_tx.sv
// pkt_enq_tx: packet traffic source for the enqueue side of the packet
// processor. It takes one command (length in words plus a data seed), waits
// for buffer space, then streams seed, seed+1, ... with SOP/EOP framing. It
// stalls on ram_full and counts sent packets and observed drops.
//
// Ports:
//   clk, sw_rst          clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_len (words), cmd_seed (word 0)
//   enq_pck_proc_almost_full  blocks the start of a new packet
//   ram_full             stalls individual beats
//   enq_packet_drop      drop pulse from the downstream block
//   enq_req, enq_in_sop, enq_in_eop, enq_wr_data_i  beat outputs
//   enq_pck_len_valid, enq_pck_len_i  length qualifier on the SOP beat
//   busy, cmd_err        status; cmd_err pulses for an illegal length
//   pkt_sent_cnt, pkt_drop_cnt  saturating statistics counters
module pkt_enq_tx #(
  parameter int MAX_LEN = 1500,
  parameter int IPG     = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             sw_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [11:0]      cmd_len,
  input  logic [31:0]      cmd_seed,
  input  logic             enq_pck_proc_almost_full,
  input  logic             ram_full,
  input  logic             enq_packet_drop,
  output logic             enq_req,
  output logic             enq_in_sop,
  output logic             enq_in_eop,
  output logic [31:0]      enq_wr_data_i,
  output logic             enq_pck_len_valid,
  output logic [11:0]      enq_pck_len_i,
  output logic             busy,
  output logic             cmd_err,
  output logic [CNT_W-1:0] pkt_sent_cnt,
  output logic [CNT_W-1:0] pkt_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    STREAM,
    GAP
  } state_t;

  localparam logic [11:0]      MAX_L   = 12'(MAX_LEN);
  localparam logic [3:0]       IPG_L   = 4'(IPG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [11:0] len;
  logic [11:0] idx;
  logic [31:0] seed;
  logic [3:0]  gap_cnt;

  logic fire_sop;
  logic fire_mid;
  logic last;

  // fire_sop/fire_mid: a beat is registered on this edge.
  // last: that beat is the EOP beat.
  always_comb begin
    fire_sop = 1'b0;
    fire_mid = 1'b0;
    last     = 1'b0;
    if (state == WAIT_SPACE)
      fire_sop = !enq_pck_proc_almost_full && !ram_full;
    if (state == STREAM)
      fire_mid = !ram_full;
    if (fire_sop && len == 12'd1)
      last = 1'b1;
    if (fire_mid && idx == len - 12'd1)
      last = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state             <= IDLE;
      len               <= '0;
      idx               <= '0;
      seed              <= '0;
      gap_cnt           <= '0;
      cmd_ready         <= 1'b0;
      enq_req           <= 1'b0;
      enq_in_sop        <= 1'b0;
      enq_in_eop        <= 1'b0;
      enq_wr_data_i     <= '0;
      enq_pck_len_valid <= 1'b0;
      enq_pck_len_i     <= '0;
      busy              <= 1'b0;
      cmd_err           <= 1'b0;
      pkt_sent_cnt      <= '0;
      pkt_drop_cnt      <= '0;
    end else begin
      // Beat outputs default to an idle cycle.
      enq_req           <= 1'b0;
      enq_in_sop        <= 1'b0;
      enq_in_eop        <= 1'b0;
      enq_wr_data_i     <= '0;
      enq_pck_len_valid <= 1'b0;
      enq_pck_len_i     <= '0;
      cmd_err           <= 1'b0;

      if (enq_packet_drop && pkt_drop_cnt != CNT_MAX)
        pkt_drop_cnt <= pkt_drop_cnt + 1'b1;

      if (last && pkt_sent_cnt != CNT_MAX)
        pkt_sent_cnt <= pkt_sent_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            len       <= cmd_len;
            seed      <= cmd_seed;
            if (cmd_len == 12'd0 || cmd_len > MAX_L) begin
              cmd_err <= 1'b1;
            end else begin
              state <= WAIT_SPACE;
              busy  <= 1'b1;
            end
          end else begin
            // Re-arms after reset and after an illegal command.
            cmd_ready <= 1'b1;
          end
        end

        WAIT_SPACE: begin
          if (fire_sop) begin
            enq_req           <= 1'b1;
            enq_in_sop        <= 1'b1;
            enq_pck_len_valid <= 1'b1;
            enq_pck_len_i     <= len;
            enq_wr_data_i     <= seed;
            enq_in_eop        <= last;
            idx               <= 12'd1;
            if (!last) begin
              state <= STREAM;
            end
          end
        end

        STREAM: begin
          if (fire_mid) begin
            enq_req       <= 1'b1;
            enq_wr_data_i <= seed + 32'(idx);
            enq_in_eop    <= last;
            idx           <= idx + 12'd1;
          end
        end

        GAP: begin
          if (gap_cnt == 4'd0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
      endcase

      // Leaving the packet: the EOP cycle counts as part of GAP, so
      // IPG idle cycles follow the EOP beat before cmd_ready returns.
      if (last) begin
        gap_cnt <= IPG_L;
        if (IPG_L == 4'd0) begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end else begin
          state <= GAP;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_enq_tx.sv
// Testbench for pkt_enq_tx: directed vector table, randomized traffic with
// a queue-based packet model, reset corner cases and counter saturation.
module tb_pkt_enq_tx;

  localparam int MAX_LEN = 1500;
  localparam int IPG     = 2;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             sw_rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [11:0]      cmd_len = '0;
  logic [31:0]      cmd_seed = '0;
  logic             enq_pck_proc_almost_full = 1'b0;
  logic             ram_full = 1'b0;
  logic             enq_packet_drop = 1'b0;
  logic             enq_req;
  logic             enq_in_sop;
  logic             enq_in_eop;
  logic [31:0]      enq_wr_data_i;
  logic             enq_pck_len_valid;
  logic [11:0]      enq_pck_len_i;
  logic             busy;
  logic             cmd_err;
  logic [CNT_W-1:0] pkt_sent_cnt;
  logic [CNT_W-1:0] pkt_drop_cnt;

  pkt_enq_tx #(
    .MAX_LEN(MAX_LEN),
    .IPG    (IPG),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                     (clk),
    .sw_rst                  (sw_rst),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_len                 (cmd_len),
    .cmd_seed                (cmd_seed),
    .enq_pck_proc_almost_full(enq_pck_proc_almost_full),
    .ram_full                (ram_full),
    .enq_packet_drop         (enq_packet_drop),
    .enq_req                 (enq_req),
    .enq_in_sop              (enq_in_sop),
    .enq_in_eop              (enq_in_eop),
    .enq_wr_data_i           (enq_wr_data_i),
    .enq_pck_len_valid       (enq_pck_len_valid),
    .enq_pck_len_i           (enq_pck_len_i),
    .busy                    (busy),
    .cmd_err                 (cmd_err),
    .pkt_sent_cnt            (pkt_sent_cnt),
    .pkt_drop_cnt            (pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [31:0] seed;
    int          af_cyc;
    int          rf_after;
    int          rf_cyc;
  } vec_t;

  int               nvec = 0;
  int               nerr = 0;
  int               cyc = 0;
  int               viol = 0;
  bit               rand_bp = 1'b0;
  logic [CNT_W-1:0] sent_model = '0;
  logic [CNT_W-1:0] drop_model = '0;
  // beat record: {sop, eop, len_valid, len[11:0], data[31:0]}
  logic [46:0]      beats[$];
  int               stamps[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit after it.
  task automatic step();
    logic p_af, p_rf, p_rst, p_drop;
    p_af   = enq_pck_proc_almost_full;
    p_rf   = ram_full;
    p_rst  = sw_rst;
    p_drop = enq_packet_drop;
    @(posedge clk);
    #1;
    cyc++;
    if (p_rst)
      drop_model = '0;
    else if (p_drop && drop_model != '1)
      drop_model = drop_model + 1'b1;
    if (enq_req) begin
      beats.push_back({enq_in_sop, enq_in_eop, enq_pck_len_valid,
                       enq_pck_len_i, enq_wr_data_i});
      stamps.push_back(cyc);
      if (p_rf)
        viol++;
    end
    if ((enq_in_sop || enq_in_eop || enq_pck_len_valid) && !enq_req)
      viol++;
    if (enq_pck_len_valid != enq_in_sop)
      viol++;
    if (enq_in_sop && p_af)
      viol++;
    if (rand_bp) begin
      ram_full                 = ($urandom_range(3) == 0);
      enq_pck_proc_almost_full = ($urandom_range(2) == 0);
      enq_packet_drop          = ($urandom_range(7) == 0);
    end
  endtask

  task automatic wait_ready(input int bound);
    for (int i = 0; i < bound && !cmd_ready; i++)
      step();
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  function automatic bit last_is_eop();
    if (beats.size() == 0)
      return 1'b0;
    return beats[beats.size()-1][45];
  endfunction

  function automatic bit legal(input int l);
    return l != 0 && l <= MAX_LEN;
  endfunction

  // Compare captured beats against the packet a command should produce.
  task automatic bad_beats(input int l, input logic [31:0] s,
                           output int bad);
    logic [31:0] d;
    logic [46:0] b;
    bit          ok;
    bad = 0;
    for (int i = 0; i < beats.size() && i < l; i++) begin
      b  = beats[i];
      d  = s + 32'(i);
      ok = (b[31:0] == d) && (b[46] == (i == 0)) &&
           (b[45] == (i == l - 1)) && (b[44] == (i == 0));
      if (i == 0 && b[43:32] != 12'(l))
        ok = 1'b0;
      if (!ok) begin
        if (bad == 0)
          $display("  beat %0d got %h exp data %h", i, b, d);
        bad++;
      end
    end
  endtask

  task automatic count_sent();
    if (sent_model != '1)
      sent_model = sent_model + 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    int bad;
    int ecyc;
    bit rf_done;
    beats.delete();
    stamps.delete();
    wait_ready(50);
    cmd_valid = 1'b1;
    cmd_len   = 12'(v.len);
    cmd_seed  = v.seed;
    enq_pck_proc_almost_full = (v.af_cyc != 0);
    step();
    acc       = cyc;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    if (!legal(v.len)) begin
      chk("err_pulse", cmd_err, 1);
      chk("err_busy", busy, 0);
      step();
      chk("err_clear", cmd_err, 0);
      repeat (4) step();
      chk("err_beats", beats.size(), 0);
      chk("err_sent", pkt_sent_cnt, sent_model);
      chk("err_busy_after", busy, 0);
      return;
    end
    repeat (v.af_cyc) step();
    if (v.af_cyc != 0)
      chk("af_hold_no_sop", beats.size(), 0);
    enq_pck_proc_almost_full = 1'b0;
    rf_done = (v.rf_cyc == 0);
    for (int i = 0; i < v.len + v.rf_cyc + 20 && !last_is_eop(); i++) begin
      if (!rf_done && beats.size() == v.rf_after + 1) begin
        ram_full = 1'b1;
        repeat (v.rf_cyc) step();
        ram_full = 1'b0;
        rf_done  = 1'b1;
      end else begin
        step();
      end
    end
    chk("eop_seen", last_is_eop(), 1);
    count_sent();
    if (last_is_eop()) begin
      ecyc = stamps[stamps.size()-1];
      chk("sop_latency", stamps[0] - acc, v.af_cyc + 1);
      chk("beat_span", ecyc - stamps[0], v.len - 1 + v.rf_cyc);
      if (v.rf_cyc != 0)
        chk("rf_gap", stamps[v.rf_after+1] - stamps[v.rf_after] - 1,
            v.rf_cyc);
      wait_ready(20);
      chk("ipg_ready", cyc - ecyc, IPG + 1);
    end
    chk("nbeats", beats.size(), v.len);
    bad_beats(v.len, v.seed, bad);
    chk("beat_data", bad, 0);
    chk("sent_cnt", pkt_sent_cnt, sent_model);
    chk("drop_cnt", pkt_drop_cnt, drop_model);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_rand(input int l, input logic [31:0] s);
    int bad;
    beats.delete();
    stamps.delete();
    wait_ready(100);
    cmd_valid = 1'b1;
    cmd_len   = 12'(l);
    cmd_seed  = s;
    step();
    cmd_valid = 1'b0;
    if (!legal(l)) begin
      chk("rnd_err", cmd_err, 1);
      repeat (3) step();
      chk("rnd_err_beats", beats.size(), 0);
    end else begin
      for (int i = 0; i < l * 10 + 100 && !last_is_eop(); i++)
        step();
      chk("rnd_eop", last_is_eop(), 1);
      count_sent();
      chk("rnd_nbeats", beats.size(), l);
      bad_beats(l, s, bad);
      chk("rnd_data", bad, 0);
    end
    chk("rnd_sent", pkt_sent_cnt, sent_model);
    chk("rnd_drop", pkt_drop_cnt, drop_model);
  endtask

  vec_t tbl[9];
  int   eops;

  initial begin
    tbl[0] = '{4,    32'h0000_0010, 0, 0, 0};
    tbl[1] = '{1,    32'hFFFF_FFFF, 0, 0, 0};
    tbl[2] = '{3,    32'hFFFF_FFFF, 0, 0, 0};
    tbl[3] = '{4,    32'h0000_A000, 5, 0, 0};
    tbl[4] = '{6,    32'h0000_0055, 0, 2, 3};
    tbl[5] = '{0,    32'h0000_0001, 0, 0, 0};
    tbl[6] = '{MAX_LEN + 1, 32'h2, 0, 0, 0};
    tbl[7] = '{MAX_LEN, 32'hDEAD_0000, 0, 0, 0};
    tbl[8] = '{2,    32'h1234_5678, 2, 0, 1};

    // Reset state
    repeat (3) step();
    chk("rst_beat", {enq_req, enq_in_sop, enq_in_eop, enq_pck_len_valid,
                     enq_pck_len_i, enq_wr_data_i}, 0);
    chk("rst_ctl", {busy, cmd_err, cmd_ready}, 0);
    chk("rst_sent", pkt_sent_cnt, 0);
    chk("rst_drop", pkt_drop_cnt, 0);
    sw_rst = 1'b0;
    step();
    chk("ready_after_rst", cmd_ready, 1);

    foreach (tbl[i])
      run_vec(tbl[i]);

    // Randomized traffic with random backpressure and drop pulses
    rand_bp = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int l;
      if ($urandom_range(9) == 0)
        l = ($urandom_range(1) == 0) ? 0 : MAX_LEN + 1 + $urandom_range(99);
      else
        l = 1 + $urandom_range(23);
      run_rand(l, $urandom);
    end
    rand_bp = 1'b0;
    ram_full = 1'b0;
    enq_pck_proc_almost_full = 1'b0;
    enq_packet_drop = 1'b0;
    step();

    // Reset and command in the same cycle
    beats.delete();
    stamps.delete();
    wait_ready(50);
    sw_rst    = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 12'd5;
    cmd_seed  = 32'h99;
    step();
    sent_model = '0;
    sw_rst    = 1'b0;
    cmd_valid = 1'b0;
    chk("rstcmd_busy", busy, 0);
    chk("rstcmd_ready", cmd_ready, 0);
    repeat (5) step();
    chk("rstcmd_beats", beats.size(), 0);
    chk("rstcmd_ready_back", cmd_ready, 1);

    // Reset in the middle of a packet
    run_vec('{3, 32'h40, 0, 0, 0});
    beats.delete();
    stamps.delete();
    wait_ready(50);
    cmd_valid = 1'b1;
    cmd_len   = 12'd10;
    cmd_seed  = 32'h100;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 30 && beats.size() < 4; i++)
      step();
    chk("mid_beats", beats.size(), 4);
    sw_rst = 1'b1;
    step();
    sent_model = '0;
    chk("mid_rst_beat", {enq_req, enq_in_sop, enq_in_eop, enq_pck_len_valid,
                         enq_pck_len_i, enq_wr_data_i}, 0);
    chk("mid_rst_ctl", {busy, cmd_err, cmd_ready}, 0);
    chk("mid_rst_sent", pkt_sent_cnt, 0);
    chk("mid_rst_drop", pkt_drop_cnt, 0);
    eops = 0;
    foreach (beats[i])
      if (beats[i][45])
        eops++;
    chk("mid_no_eop", eops, 0);
    sw_rst = 1'b0;
    step();
    chk("mid_ready", cmd_ready, 1);
    run_vec('{2, 32'h77, 0, 0, 0});

    // Drop counter saturation, with a packet streamed during drops
    enq_packet_drop = 1'b1;
    run_vec('{8, 32'h1234_0000, 0, 0, 0});
    for (int i = 0; i < 70000 && drop_model != '1; i++)
      step();
    chk("drop_reach_max", pkt_drop_cnt, 16'hFFFF);
    repeat (3) step();
    chk("drop_sat_hold", pkt_drop_cnt, 16'hFFFF);
    enq_packet_drop = 1'b0;
    step();

    chk("protocol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
